pc_gen: RTL and testbench

Registered fetch-PC generator for the pipelined RV32 core, replacing the purely combinational PC selection step. It holds the fetch PC and applies stall and EX-stage redirects. It resolves B-type, JAL and JALR outcomes with the existing Btype/branch_result encoding and predicts fetch redirects from a direct-mapped branch target buffer (BTB). It sits between the hazard unit / EX stage and the instruction-memory address port.

---
 rtl/pc_gen.sv | 164 ++++++++++++++++
 tb/tb_pc_gen.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Registered fetch-PC generator with EX-stage redirect and optional direct-mapped BTB (PC_GEN_BTB_EN).
// Latency: redirect or stall resolved in cycle N shows on pc_o in N+1; prediction outputs are combinational.
// Backpressure: stall_i holds pc_o; a mispredict overrides stall_i and flush_o squashes IF/ID and ID/EX.
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BTB_DEPTH = 16,
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  output logic [XLEN-1:0]  pc_o,
  output logic             pred_taken_o,
  output logic [XLEN-1:0]  pred_target_o,
  input  logic             ex_valid_i,
  input  logic [XLEN-1:0]  ex_pc_i,
  input  logic [XLEN-1:0]  ex_npc_i,
  input  logic [2:0]       ex_btype_i,
  input  logic [2:0]       ex_branch_result_i,
  input  logic             ex_ijalr_i,
  input  logic             ex_jtype_i,
  input  logic             ex_pred_taken_i,
  input  logic [XLEN-1:0]  ex_pred_target_i,
  output logic             flush_o,
  output logic [CNT_W-1:0] mispredict_cnt_o
);

  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  pc_plus4;
  logic [XLEN-1:0]  ex_plus4;
  logic [XLEN-1:0]  actual_next;
  logic [CNT_W-1:0] mis_cnt_q;
  logic             is_jump;
  logic             actual_taken;
  logic             mispredict;
  logic             res_eq;
  logic             res_lt;
  logic             res_gt;

  // Mispredict is judged on the target alone; the carried taken bit is informational.
  logic unused_pred_taken;
  assign unused_pred_taken = ex_pred_taken_i;

  assign pc_plus4 = pc_q + FOUR;
  assign ex_plus4 = ex_pc_i + FOUR;
  assign is_jump  = ex_jtype_i | ex_ijalr_i;
  assign res_eq   = ex_branch_result_i[0];
  assign res_lt   = ex_branch_result_i[1];
  assign res_gt   = ex_branch_result_i[2];

  always_comb begin
    actual_taken = 1'b0;
    if (is_jump) begin
      actual_taken = 1'b1;
    end else begin
      case (ex_btype_i)
        3'b100:  actual_taken = res_eq;
        3'b101:  actual_taken = ~res_eq;
        3'b110:  actual_taken = res_lt;
        3'b111:  actual_taken = res_eq | res_gt;
        default: actual_taken = 1'b0;
      endcase
    end
  end

  assign actual_next = actual_taken ? ex_npc_i : ex_plus4;
  assign mispredict  = rst_n & ex_valid_i & (actual_next != ex_pred_target_i);
  assign flush_o     = mispredict;

`ifdef PC_GEN_BTB_EN
  localparam int IDX   = $clog2(BTB_DEPTH);
  localparam int TAG_W = XLEN - IDX - 2;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic [1:0]       cnt;
  } btb_ent_t;

  btb_ent_t             btb_q [BTB_DEPTH];
  logic [BTB_DEPTH-1:0] btb_vld_q;
  logic [IDX-1:0]       rd_idx;
  logic [IDX-1:0]       wr_idx;
  btb_ent_t             rd_ent;
  btb_ent_t             wr_ent;
  btb_ent_t             wr_dat;
  logic                 rd_hit;
  logic                 wr_hit;
  logic                 wr_en;
  logic                 is_branch;

  assign rd_idx    = pc_q[IDX+1:2];
  assign rd_ent    = btb_q[rd_idx];
  assign rd_hit    = btb_vld_q[rd_idx] && (rd_ent.tag == pc_q[XLEN-1:IDX+2]);
  assign wr_idx    = ex_pc_i[IDX+1:2];
  assign wr_ent    = btb_q[wr_idx];
  assign wr_hit    = btb_vld_q[wr_idx] && (wr_ent.tag == ex_pc_i[XLEN-1:IDX+2]);
  assign is_branch = ex_btype_i[2];

  assign pred_taken_o  = rst_n & rd_hit & rd_ent.cnt[1];
  assign pred_target_o = !rst_n       ? RESET_PC + FOUR :
                         pred_taken_o ? rd_ent.target   : pc_plus4;

  always_comb begin
    wr_en  = 1'b0;
    wr_dat = wr_ent;
    if (rst_n && ex_valid_i && (is_jump || is_branch)) begin
      if (actual_taken) begin
        wr_en         = 1'b1;
        wr_dat.tag    = ex_pc_i[XLEN-1:IDX+2];
        wr_dat.target = ex_npc_i;
        if (is_jump)
          wr_dat.cnt = 2'b11;
        else if (wr_hit)
          wr_dat.cnt = (wr_ent.cnt == 2'b11) ? 2'b11 : wr_ent.cnt + 2'd1;
        else
          wr_dat.cnt = 2'b10;
      end else if (wr_hit) begin
        // Not-taken hit only weakens the counter; the entry keeps its target.
        wr_en      = 1'b1;
        wr_dat.cnt = (wr_ent.cnt == 2'b00) ? 2'b00 : wr_ent.cnt - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      btb_vld_q <= '0;
    else if (wr_en)
      btb_vld_q[wr_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      btb_q[wr_idx] <= wr_dat;
  end
`else
  assign pred_taken_o  = 1'b0;
  assign pred_target_o = !rst_n ? RESET_PC + FOUR : pc_plus4;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n)
      pc_q <= RESET_PC;
    else if (mispredict)
      pc_q <= actual_next;
    else if (!stall_i)
      pc_q <= pred_target_o;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      mis_cnt_q <= '0;
    else if (mispredict && (mis_cnt_q != '1))
      mis_cnt_q <= mis_cnt_q + CNT_W'(1);
  end

  assign pc_o             = pc_q;
  assign mispredict_cnt_o = mis_cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed plus randomized bench for pc_gen against a table-level model of fetch, resolution and BTB rules.
module tb_pc_gen;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 16;
  localparam int          CW    = 6;
  localparam logic [31:0] RPC   = 32'h100;
`ifdef PC_GEN_BTB_EN
  localparam bit BTB_EN = 1'b1;
`else
  localparam bit BTB_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall_i;
  logic [31:0]   pc_o;
  logic          pred_taken_o;
  logic [31:0]   pred_target_o;
  logic          ex_valid_i;
  logic [31:0]   ex_pc_i;
  logic [31:0]   ex_npc_i;
  logic [2:0]    ex_btype_i;
  logic [2:0]    ex_branch_result_i;
  logic          ex_ijalr_i;
  logic          ex_jtype_i;
  logic          ex_pred_taken_i;
  logic [31:0]   ex_pred_target_i;
  logic          flush_o;
  logic [CW-1:0] mispredict_cnt_o;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(XLEN), .RESET_PC(RPC), .BTB_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .pc_o(pc_o),
    .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
    .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i), .ex_npc_i(ex_npc_i),
    .ex_btype_i(ex_btype_i), .ex_branch_result_i(ex_branch_result_i),
    .ex_ijalr_i(ex_ijalr_i), .ex_jtype_i(ex_jtype_i),
    .ex_pred_taken_i(ex_pred_taken_i), .ex_pred_target_i(ex_pred_target_i),
    .flush_o(flush_o), .mispredict_cnt_o(mispredict_cnt_o)
  );

  int tests = 0;
  int fails = 0;

  // Model: fetch PC, mispredict count, and a table of branches keyed by slot holding the full branch PC.
  logic [31:0] m_pc;
  int          m_cnt;
  bit          m_v   [DEPTH];
  logic [31:0] m_key [DEPTH];
  logic [31:0] m_tgt [DEPTH];
  int          m_ctr [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  function automatic bit same_branch(input int s, input logic [31:0] pc);
    logic [31:0] k;
    k = m_key[s];
    return m_v[s] && (k[31:2] == pc[31:2]);
  endfunction

  task automatic predict(input logic [31:0] pc, output bit tk, output logic [31:0] tgt);
    int s;
    s   = slot(pc);
    tk  = BTB_EN && same_branch(s, pc) && (m_ctr[s] >= 2);
    tgt = tk ? m_tgt[s] : pc + 32'd4;
  endtask

  function automatic bit rule_taken(input logic [2:0] bt, input logic [2:0] br, input bit jr, input bit j);
    if (j || jr) return 1'b1;
    case (bt)
      3'b100:  return br == 3'b001;
      3'b101:  return br != 3'b001;
      3'b110:  return br == 3'b010;
      3'b111:  return (br == 3'b001) || (br == 3'b100);
      default: return 1'b0;
    endcase
  endfunction

  task automatic learn(input logic [31:0] pc, input logic [31:0] npc, input bit tk, input bit jump);
    int s;
    bit hit;
    s   = slot(pc);
    hit = same_branch(s, pc);
    if (tk) begin
      m_ctr[s] = jump ? 3 : (hit ? ((m_ctr[s] < 3) ? m_ctr[s] + 1 : 3) : 2);
      m_key[s] = pc;
      m_tgt[s] = npc;
      m_v[s]   = 1'b1;
    end else if (hit) begin
      m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
    end
  endtask

  task automatic step(input bit rst, input bit stall, input bit vld, input logic [31:0] epc,
                      input logic [31:0] enpc, input logic [2:0] bt, input logic [2:0] br,
                      input bit jr, input bit j, input logic [31:0] ptgt);
    bit          p_tk;
    logic [31:0] p_tgt;
    bit          tk;
    logic [31:0] nxt;
    bit          mis;
    rst_n              = rst;
    stall_i            = stall;
    ex_valid_i         = vld;
    ex_pc_i            = epc;
    ex_npc_i           = enpc;
    ex_btype_i         = bt;
    ex_branch_result_i = br;
    ex_ijalr_i         = jr;
    ex_jtype_i         = j;
    ex_pred_target_i   = ptgt;
    ex_pred_taken_i    = (ptgt != epc + 32'd4);
    predict(m_pc, p_tk, p_tgt);
    tk  = vld && rule_taken(bt, br, jr, j);
    nxt = tk ? enpc : epc + 32'd4;
    mis = rst && vld && (nxt != ptgt);
    @(negedge clk);
    if (rst) begin
      chk("pc_now", pc_o, m_pc);
      chk("pred_taken", pred_taken_o, p_tk);
      chk("pred_target", pred_target_o, p_tgt);
      chk("flush", flush_o, mis);
    end else begin
      chk("rst_pred_taken", pred_taken_o, 1'b0);
      chk("rst_pred_target", pred_target_o, RPC + 32'd4);
    end
    @(posedge clk);
    if (!rst) begin
      m_pc  = RPC;
      m_cnt = 0;
      foreach (m_v[i]) m_v[i] = 1'b0;
    end else begin
      if (BTB_EN && vld && ((bt inside {3'b100, 3'b101, 3'b110, 3'b111}) || j || jr))
        learn(epc, enpc, tk, j || jr);
      if (mis && (m_cnt < (1 << CW) - 1)) m_cnt = m_cnt + 1;
      m_pc = mis ? nxt : (stall ? m_pc : p_tgt);
    end
    #1;
    chk("pc_next", pc_o, m_pc);
    chk("mis_cnt", 32'(mispredict_cnt_o), m_cnt);
  endtask

  task automatic idle(input bit stall);
    step(1'b1, stall, 1'b0, 32'h0, 32'h0, 3'b000, 3'b001, 1'b0, 1'b0, 32'h0);
  endtask

  // A non-control instruction carrying a wrong target forces fetch to epc+4.
  task automatic go_to(input logic [31:0] pc);
    step(1'b1, 1'b0, 1'b1, pc - 32'd4, 32'h0, 3'b000, 3'b001, 1'b0, 1'b0, 32'hdead_bee0);
  endtask

  initial begin
    bit          r_vld, r_stall, r_j, r_jr, tk;
    logic [2:0]  r_bt, r_br;
    logic [31:0] r_pc, r_npc, r_pt, tg;
    int          sel;
    rst_n = 1'b0; stall_i = 1'b0; ex_valid_i = 1'b0; ex_pc_i = '0; ex_npc_i = '0;
    ex_btype_i = '0; ex_branch_result_i = 3'b001; ex_ijalr_i = 1'b0; ex_jtype_i = 1'b0;
    ex_pred_taken_i = 1'b0; ex_pred_target_i = '0;
    m_pc = RPC; m_cnt = 0;

    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 3'b001, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 3'b001, 1'b0, 1'b0, 32'h0);
    chk("reset_pc", pc_o, 32'h100);
    chk("reset_cnt", 32'(mispredict_cnt_o), 32'h0);
    idle(1'b0); idle(1'b0);
    chk("seq_pc", pc_o, 32'h108);
    idle(1'b0);

    step(1'b1, 1'b0, 1'b1, 32'h200, 32'h8, 3'b000, 3'b001, 1'b0, 1'b1, 32'h204);
    chk("jal_redirect", pc_o, 32'h8);
    idle(1'b1); idle(1'b1);
    chk("stall_hold", pc_o, 32'h8);
    step(1'b1, 1'b1, 1'b1, 32'h10, 32'h40, 3'b100, 3'b001, 1'b0, 1'b0, 32'h14);
    chk("beq_redirect_in_stall", pc_o, 32'h40);
    chk("beq_cnt", 32'(mispredict_cnt_o), 32'd2);
    go_to(32'h10);
    chk("reissue_taken", pred_taken_o, BTB_EN);
    chk("reissue_target", pred_target_o, BTB_EN ? 32'h40 : 32'h14);

    step(1'b1, 1'b0, 1'b1, 32'h10, 32'h40, 3'b111, 3'b010, 1'b0, 1'b0, BTB_EN ? 32'h40 : 32'h14);
    chk("bge_lt_pc", pc_o, 32'h14);
    go_to(32'h10);
    chk("weak_taken", pred_taken_o, 1'b0);
    chk("weak_target", pred_target_o, 32'h14);

    step(1'b1, 1'b0, 1'b1, 32'h50, 32'h80, 3'b000, 3'b001, 1'b0, 1'b1, 32'h54);
    go_to(32'h50);
    chk("alias_jal_taken", pred_taken_o, BTB_EN);
    chk("alias_jal_target", pred_target_o, BTB_EN ? 32'h80 : 32'h54);
    go_to(32'h10);
    chk("alias_evicted", pred_taken_o, 1'b0);

    step(1'b1, 1'b0, 1'b1, 32'h300, 32'hffff_fff8, 3'b000, 3'b001, 1'b1, 1'b0, 32'h304);
    idle(1'b0); idle(1'b0);
    chk("pc_wrap", pc_o, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'hffff_fffc, 32'h800, 3'b100, 3'b010, 1'b0, 1'b0, 32'h8);
    chk("ex_wrap", pc_o, 32'h0);

    step(1'b0, 1'b0, 1'b1, 32'h20, 32'h500, 3'b000, 3'b001, 1'b0, 1'b1, 32'h24);
    chk("reset_wins_pc", pc_o, RPC);
    chk("reset_wins_cnt", 32'(mispredict_cnt_o), 32'h0);

    for (int n = 0; n < 400; n++) begin
      r_vld   = ($urandom_range(0, 9) < 7);
      r_stall = ($urandom_range(0, 3) == 0);
      r_pc    = 32'($urandom_range(0, 127)) << 2;
      r_npc   = 32'($urandom_range(0, 255)) << 2;
      r_bt    = 3'($urandom_range(0, 7));
      r_br    = 3'b001 << $urandom_range(0, 2);
      sel     = $urandom_range(0, 9);
      r_j     = (sel == 0);
      r_jr    = (sel == 1);
      case ($urandom_range(0, 2))
        0:       r_pt = r_pc + 32'd4;
        1:       begin predict(r_pc, tk, tg); r_pt = tg; end
        default: r_pt = 32'($urandom_range(0, 255)) << 2;
      endcase
      step(1'b1, r_stall, r_vld, r_pc, r_npc, r_bt, r_br, r_jr, r_j, r_pt);
    end

    for (int n = 0; n < (1 << CW) + 3; n++) go_to(32'h10);
    chk("cnt_saturate", 32'(mispredict_cnt_o), 32'((1 << CW) - 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
